// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: 16-state TAP controller with IR/DR strobes, BYPASS register and TDO mux
module jtag_tap_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tms,
  input  logic       tdi,
  input  logic       ir_so,
  input  logic       dr_so,
  input  logic       bypass_sel,
  output logic [3:0] state,
  output logic       tlr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       tdo,
  output logic       tdo_en
);
  typedef enum logic [3:0] {
    EX2DR   = 4'h0,
    EX1DR   = 4'h1,
    SHDR    = 4'h2,
    PAUSEDR = 4'h3,
    SELIR   = 4'h4,
    UPDDR   = 4'h5,
    CAPDR   = 4'h6,
    SELDR   = 4'h7,
    EX2IR   = 4'h8,
    EX1IR   = 4'h9,
    SHIR    = 4'hA,
    PAUSEIR = 4'hB,
    RTI     = 4'hC,
    UPDIR   = 4'hD,
    CAPIR   = 4'hE,
    TLR     = 4'hF
  } tap_e;
  tap_e state_q, state_d;
  logic bypass_q, bypass_d;
  // TAP next-state table; the IR and DR columns mirror each other
  always_comb begin
    state_d = TLR;
    case (state_q)
      TLR:     state_d = tms ? TLR     : RTI;
      RTI:     state_d = tms ? SELDR   : RTI;
      SELDR:   state_d = tms ? SELIR   : CAPDR;
      CAPDR:   state_d = tms ? EX1DR   : SHDR;
      SHDR:    state_d = tms ? EX1DR   : SHDR;
      EX1DR:   state_d = tms ? UPDDR   : PAUSEDR;
      PAUSEDR: state_d = tms ? EX2DR   : PAUSEDR;
      EX2DR:   state_d = tms ? UPDDR   : SHDR;
      UPDDR:   state_d = tms ? SELDR   : RTI;
      SELIR:   state_d = tms ? TLR     : CAPIR;
      CAPIR:   state_d = tms ? EX1IR   : SHIR;
      SHIR:    state_d = tms ? EX1IR   : SHIR;
      EX1IR:   state_d = tms ? UPDIR   : PAUSEIR;
      PAUSEIR: state_d = tms ? EX2IR   : PAUSEIR;
      EX2IR:   state_d = tms ? UPDIR   : SHIR;
      UPDIR:   state_d = tms ? SELDR   : RTI;
      default: state_d = TLR;
    endcase
  end
  // BYPASS captures 0 and then shifts tdi only when it is the selected DR
  always_comb begin
    bypass_d = bypass_q;
    if (bypass_sel && state_q == CAPDR) bypass_d = 1'b0;
    else if (bypass_sel && state_q == SHDR) bypass_d = tdi;
  end
  // state and BYPASS registers; reset overrides tms even mid-shift
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= tap_e'(RESET_STATE);
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bypass_q <= bypass_d;
    end
  end
  // Moore strobe decode and TDO mux
  always_comb begin
    state      = state_q;
    tlr        = state_q == TLR;
    capture_ir = state_q == CAPIR;
    shift_ir   = state_q == SHIR;
    update_ir  = state_q == UPDIR;
    capture_dr = state_q == CAPDR;
    shift_dr   = state_q == SHDR;
    update_dr  = state_q == UPDDR;
    tdo_en     = shift_ir | shift_dr;
    tdo        = shift_ir ? ir_so : shift_dr ? (bypass_sel ? bypass_q : dr_so) : 1'b0;
  end
endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: scoreboard bench for the TAP controller
module tb_jtag_tap_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1, tms = 1'b1, tdi = 1'b0, ir_so = 1'b0, dr_so = 1'b0, bypass_sel = 1'b0;
  logic [3:0] state;
  logic tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr, tdo, tdo_en;
  int errors = 0, checks = 0;

  typedef struct {
    bit          care;
    logic [12:0] obs;
    string       name;
  } exp_t;
  exp_t sb[$];

  jtag_tap_ctrl dut (
    .clk(clk), .reset(reset), .tms(tms), .tdi(tdi), .ir_so(ir_so), .dr_so(dr_so),
    .bypass_sel(bypass_sel), .state(state), .tlr(tlr), .capture_ir(capture_ir),
    .shift_ir(shift_ir), .update_ir(update_ir), .capture_dr(capture_dr),
    .shift_dr(shift_dr), .update_dr(update_dr), .tdo(tdo), .tdo_en(tdo_en)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] expect_of(input logic [3:0] s, input logic o);
    return {s, s == 4'hF, s == 4'hE, s == 4'hA, s == 4'hD, s == 4'h6, s == 4'h2, s == 4'h5,
            o, (s == 4'hA) || (s == 4'h2)};
  endfunction

  // monitor: every cycle the DUT presents a new state; compare against the scoreboard head
  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      logic [12:0] act;
      e = sb.pop_front();
      act = {state, tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr, tdo, tdo_en};
      if (e.care) begin
        checks++;
        if (act !== e.obs) begin
          errors++;
          $display("FAIL %s: got state=%h strobes=%b tdo=%b en=%b, want state=%h strobes=%b tdo=%b en=%b",
                   e.name, act[12:9], act[8:2], act[1], act[0], e.obs[12:9], e.obs[8:2], e.obs[1], e.obs[0]);
        end
      end
    end
  end

  task automatic step(input logic t, input logic [3:0] s, input logic o, input string n, input bit care = 1'b1);
    exp_t e;
    tms = t;
    e.care = care;
    e.obs = expect_of(s, o);
    e.name = n;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic t);
    reset = 1'b1;
    step(t, 4'hF, 1'b0, "reset");
    reset = 1'b0;
  endtask

  string paths[16];
  logic [3:0] targets[16];

  initial begin
    paths = '{"", "0", "01", "010", "0100", "0101", "01010", "010101",
              "01011", "011", "0110", "01100", "01101", "011010", "0110101", "011011"};
    targets = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
    @(negedge clk);
    do_reset(1'b1);
    step(1'b1, 4'hF, 1'b0, "tlr_hold");
    ir_so = 1'b1;
    step(1'b0, 4'hC, 1'b0, "ir_rti");
    step(1'b1, 4'h7, 1'b0, "ir_seldr");
    step(1'b1, 4'h4, 1'b0, "ir_selir");
    step(1'b0, 4'hE, 1'b0, "ir_capture");
    step(1'b0, 4'hA, 1'b1, "ir_shift_so1");
    ir_so = 1'b0;
    step(1'b0, 4'hA, 1'b0, "ir_shift_so0");
    step(1'b1, 4'h9, 1'b0, "ir_exit1");
    step(1'b1, 4'hD, 1'b0, "ir_update");
    step(1'b0, 4'hC, 1'b0, "ir_upd_to_rti");
    step(1'b1, 4'h7, 1'b0, "rti_to_seldr");
    step(1'b0, 4'h6, 1'b0, "dr_capture");
    step(1'b0, 4'h2, 1'b0, "dr_shift");
    do_reset(1'b0);
    do_reset(1'b0);
    step(1'b0, 4'hC, 1'b0, "bp_rti");
    bypass_sel = 1'b1;
    step(1'b1, 4'h7, 1'b0, "bp_seldr");
    step(1'b0, 4'h6, 1'b0, "bp_capture");
    step(1'b0, 4'h2, 1'b0, "bp_shift_cap0");
    tdi = 1'b1;
    step(1'b0, 4'h2, 1'b1, "bp_tdi1");
    tdi = 1'b0;
    step(1'b0, 4'h2, 1'b0, "bp_tdi0");
    tdi = 1'b1;
    step(1'b0, 4'h2, 1'b1, "bp_tdi1b");
    step(1'b0, 4'h2, 1'b1, "bp_tdi1c");
    bypass_sel = 1'b0;
    dr_so = 1'b0;
    step(1'b0, 4'h2, 1'b0, "dr_so0");
    dr_so = 1'b1;
    step(1'b0, 4'h2, 1'b1, "dr_so1");
    dr_so = 1'b0;
    step(1'b1, 4'h1, 1'b0, "pause_ex1");
    step(1'b0, 4'h3, 1'b0, "pause_a");
    step(1'b0, 4'h3, 1'b0, "pause_b");
    step(1'b0, 4'h3, 1'b0, "pause_c");
    step(1'b1, 4'h0, 1'b0, "pause_ex2");
    step(1'b0, 4'h2, 1'b0, "pause_reshift");
    step(1'b1, 4'h1, 1'b0, "dr_ex1");
    step(1'b1, 4'h5, 1'b0, "dr_update");
    step(1'b0, 4'hC, 1'b0, "dr_upd_to_rti");
    for (int i = 0; i < 16; i++) begin
      string p;
      p = paths[i];
      do_reset(1'b1);
      for (int k = 0; k < p.len(); k++)
        step(p[k] == "1", targets[i], 1'b0, "walk", k == p.len() - 1);
      for (int k = 0; k < 5; k++)
        step(1'b1, 4'hF, 1'b0, $sformatf("five_ones_from_%h", targets[i]), k == 4);
    end
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
IEEE 1149.1-style TAP controller that sequences the instruction register and the data registers of the boundary-scan chain. It tracks TMS through the 16-state TAP state machine and produces the IR/DR control strobes (capture, shift, update) from the current state. It also holds the 1-bit BYPASS register and muxes TDO between IR, the selected DR and BYPASS. The IR's decode output feeds back in as bypass_sel.

Parameters:
RESET_STATE, 4'hF, encoding loaded on reset (Test-Logic-Reset); not to be overridden in normal use.

Ports:
clk  input  1  test clock (TCK domain); all state changes on the rising edge
reset  input  1  synchronous, active-high; forces Test-Logic-Reset
tms  input  1  test mode select, sampled on rising clk
tdi  input  1  serial test data in
ir_so  input  1  serial out of the instruction register
dr_so  input  1  serial out of the selected data register
bypass_sel  input  1  from IR decode; 1 = BYPASS is the active DR
state  output  4  current TAP state (encoding below)
tlr  output  1  high in Test-Logic-Reset
capture_ir, shift_ir, update_ir  output  1 each  IR strobes
capture_dr, shift_dr, update_dr  output  1 each  DR strobes (also suppressed nowhere; DR side ignores them when bypass_sel=1)
tdo  output  1  serial test data out
tdo_en  output  1  high while shifting IR or DR

Behaviour:
- State encoding (hex): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- Transitions, next state for tms=0 / tms=1:
  TLR: RTI / TLR. RTI: RTI / SelDR. SelDR: CapDR / SelIR. SelIR: CapIR / TLR.
  CapXR: ShXR / Ex1XR. ShXR: ShXR / Ex1XR. Ex1XR: PauseXR / UpdXR.
  PauseXR: PauseXR / Ex2XR. Ex2XR: ShXR / UpdXR. UpdXR: RTI / SelDR (X = D or I).
- Any illegal encoding is unreachable; the default branch goes to TLR.
- reset=1 at a rising edge: state<=F and bypass_reg<=0, regardless of tms or current state, including mid-shift. reset wins over tms.
- Five consecutive tms=1 edges reach TLR from any state without reset.
- Strobes are Moore decodes of state, combinational, one-hot among the six:
  capture_ir=(state==E), shift_ir=(A), update_ir=(D).
  capture_dr=(6), shift_dr=(2), update_dr=(5). tlr=(F).
  Each update strobe is high for exactly one clk per visit, since UpdXR always exits.
- BYPASS register, 1 bit:
  - In CapDR with bypass_sel=1: loads 0.
  - In ShDR with bypass_sel=1: loads tdi.
  - Otherwise holds.
- tdo (combinational):
  - shift_ir: ir_so.
  - shift_dr and bypass_sel: bypass_reg.
  - shift_dr and !bypass_sel: dr_so.
  - Otherwise 0.
- tdo_en = shift_ir | shift_dr.
- All outputs after reset: state=F, tlr=1, other strobes 0, tdo=0, tdo_en=0.
- Latency: a tms value sampled at edge n sets state, and therefore the strobes, visible after edge n. BYPASS gives 1-clock tdi-to-tdo delay.

Test Plan:
- reset=1 for 1 clk from arbitrary state (e.g. ShDR) -> state=F, tlr=1, all strobes 0, tdo_en=0 the cycle after.
- From TLR, tms 0,1,1,0,0 -> states C,7,4,E,A; capture_ir high exactly in E; shift_ir=1 and tdo=ir_so in A.
- From ShIR, tms 1,1,0 -> 9, D, C; update_ir high exactly one clk; tms 1 again -> 7.
- DR path with bypass_sel=1, tms 1,0,0 from RTI to reach ShDR, then tdi 1,0,1,1 with tms=0 -> tdo 0,1,0,1 (capture 0 then 1-clk delay); bypass_sel=0 -> tdo follows dr_so.
- Pause loop: ShDR, tms 1,0,0,0,1,0 -> 1,3,3,3,0,2; shift_dr low during pause, back high in 2.
- From each of the 16 states, tms=1 for 5 clks -> state=F. Also reset asserted simultaneously with tms=0 in TLR -> stays F, not C.
